uart_tx_scheduler: RTL and testbench

//  Shares the single uart_send transmitter between NREQ message sources (e.g. frequency report, status/alarm).

---
 rtl/uart_tx_scheduler_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 41 ++++
 rtl/uart_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler_pkg
//  Brief    : Shared FSM state encoding and sizing helper for the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_GAP       = 3'd5
    } sched_state_t;

    // Counter width able to hold max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler_if
//  Brief    : Requester byte streams plus the uart_send strobe/busy pair.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_scheduler_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              uart_en;
    logic [7:0]        uart_din;
    logic              uart_tx_busy;

    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, grant, uart_en, uart_din
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, grant, uart_en, uart_din
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler_rr_arbiter
//  Brief    : Round-robin pick: lowest requesting index at or after ptr.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_scheduler_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  wire logic [NREQ-1:0]          req,
    input  wire logic [$clog2(NREQ)-1:0]  ptr,
    output logic      [NREQ-1:0]          winner,
    output logic      [$clog2(NREQ)-1:0]  winner_idx,
    output logic                          any_req
);
    localparam int c_IDX_W = $clog2(NREQ);

    int                 w_pos;
    logic [c_IDX_W-1:0] w_sel;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        w_pos      = 0;
        w_sel      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_sel = c_IDX_W'(w_pos);
            if (!any_req && req[w_sel]) begin
                any_req       = 1'b1;
                winner[w_sel] = 1'b1;
                winner_idx    = w_sel;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Brief    : Shares one uart_send between NREQ sources, whole messages, RR.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int BUSY_TIMEOUT = 8,
    parameter int GAP_CYCLES   = 0
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst_n,
    uart_tx_scheduler_if.slave bus,
    output logic               sched_busy,
    output logic               timeout_err,
    output logic [15:0]        bytes_sent
);
    localparam int c_IDX_W    = $clog2(NREQ);
    localparam int c_TO_W     = cnt_width(BUSY_TIMEOUT);
    localparam int c_GAP_W    = cnt_width(GAP_CYCLES);
    localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [NREQ-1:0]    r_grant;
    logic [c_IDX_W-1:0] r_win_idx;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [7:0]         r_din;
    logic               r_last;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_timeout;
    logic [15:0]        r_bytes;

    logic [NREQ-1:0]    w_win_onehot;
    logic [c_IDX_W-1:0] w_win_idx;
    logic               w_any;
    logic               w_xfer;
    logic               w_to_hit;
    logic               w_gap_done;
    logic [c_IDX_W-1:0] w_next_ptr;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;

    uart_tx_scheduler_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (bus.req_valid),
        .ptr        (r_rr_ptr),
        .winner     (w_win_onehot),
        .winner_idx (w_win_idx),
        .any_req    (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data = w_sel_data | bus.req_data[8*i +: 8];
            end
        end
    end

    assign w_sel_last = |(r_grant & bus.req_last);
    assign w_xfer     = (r_state == ST_FETCH) && |(r_grant & bus.req_valid);
    assign w_to_hit   = (r_to_cnt == c_TO_W'(BUSY_TIMEOUT));
    assign w_gap_done = (r_gap_cnt == c_GAP_W'(c_GAP_LAST));
    assign w_next_ptr = (r_win_idx == c_IDX_W'(NREQ - 1)) ? '0 : r_win_idx + c_IDX_W'(1);

    assign bus.req_ready = (r_state == ST_FETCH) ? (r_grant & bus.req_valid) : '0;
    assign bus.grant     = r_grant;
    assign bus.uart_en   = (r_state == ST_STROBE);
    assign bus.uart_din  = r_din;
    assign sched_busy    = (r_state != ST_IDLE);
    assign timeout_err   = r_timeout;
    assign bytes_sent    = r_bytes;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      if (w_any) w_state_nxt = ST_FETCH;
            ST_FETCH:     if (w_xfer) w_state_nxt = ST_STROBE;
            ST_STROBE:    w_state_nxt = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (bus.uart_tx_busy) begin
                    w_state_nxt = ST_WAIT_FALL;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_FALL: begin
                if (!bus.uart_tx_busy) begin
                    if (!r_last) begin
                        w_state_nxt = ST_FETCH;
                    end else if (GAP_CYCLES > 0) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP:       if (w_gap_done) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant is only released at message end or on abort, so a stalled owner keeps the link.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant   <= '0;
            r_win_idx <= '0;
            r_rr_ptr  <= '0;
            r_din     <= '0;
            r_last    <= 1'b0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_timeout <= 1'b0;
            r_bytes   <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_win_onehot;
                        r_win_idx <= w_win_idx;
                    end
                end
                ST_FETCH: begin
                    if (w_xfer) begin
                        r_din  <= w_sel_data;
                        r_last <= w_sel_last;
                    end
                end
                ST_STROBE: begin
                    r_to_cnt <= '0;
                end
                ST_WAIT_RISE: begin
                    if (!bus.uart_tx_busy) begin
                        if (w_to_hit) begin
                            r_timeout <= 1'b1;
                            r_grant   <= '0;
                            r_rr_ptr  <= w_next_ptr;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                end
                ST_WAIT_FALL: begin
                    if (!bus.uart_tx_busy) begin
                        r_bytes <= r_bytes + 16'd1;
                        if (r_last) begin
                            r_grant   <= '0;
                            r_rr_ptr  <= w_next_ptr;
                            r_gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_scheduler
//  Brief    : Randomized scoreboard bench with a message-level round-robin model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;
    localparam int NREQ         = 3;
    localparam int BUSY_TIMEOUT = 8;
    localparam int GAP_CYCLES   = 2;
    localparam int MAX_WAIT     = 3000;

    typedef struct { logic [7:0] d; bit last; int dly; } item_t;
    typedef struct { int src; logic [7:0] d; bit to; } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        sched_busy;
    logic        timeout_err;
    logic [15:0] bytes_sent;

    uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    uart_tx_scheduler #(
        .NREQ         (NREQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus),
        .sched_busy  (sched_busy),
        .timeout_err (timeout_err),
        .bytes_sent  (bytes_sent)
    );

    always #5 sys_clk = ~sys_clk;

    item_t      srcq[NREQ][$];
    item_t      mdl_q[NREQ][$];
    exp_t       expq[$];
    logic [7:0] mb[8];
    int total = 0, bad = 0, cyc = 0;
    int mptr = 0, exp_bytes = 0;
    bit busy_en = 1'b1;
    int n_strobe = 0, n_timeout = 0, last_strobe = -100, first_strobe = -1, first_grant = 0;
    bit pend_to = 1'b0, prev_en = 1'b0;
    logic [7:0] held_din = 8'h00;
    bit presenting[NREQ], took[NREQ], at_start[NREQ];
    int wait_cnt[NREQ], start_cyc[NREQ];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: whole messages, lowest pending index at or after the pointer wins.
    task automatic plan(input bit to);
        int    found;
        item_t it;
        exp_t  e;
        forever begin
            found = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (found < 0 && mdl_q[(mptr + k) % NREQ].size() > 0) found = (mptr + k) % NREQ;
            end
            if (found < 0) break;
            do begin
                it    = mdl_q[found].pop_front();
                e.src = found; e.d = it.d; e.to = to;
                expq.push_back(e);
                if (!to) exp_bytes++;
            end while (!it.last);
            mptr = (found + 1) % NREQ;
        end
    endtask

    task automatic add_msg(input int s, input int len, input int dly);
        item_t it;
        for (int i = 0; i < len; i++) begin
            it.d = mb[i]; it.last = (i == len - 1); it.dly = (i == 0) ? 0 : dly;
            srcq[s].push_back(it);
            mdl_q[s].push_back(it);
        end
    endtask

    task automatic clear_all();
        for (int s = 0; s < NREQ; s++) begin
            srcq[s].delete(); mdl_q[s].delete();
            presenting[s] = 1'b0; took[s] = 1'b0; at_start[s] = 1'b1; wait_cnt[s] = 0;
        end
        expq.delete();
        mptr = 0; exp_bytes = 0;
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); sys_rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < MAX_WAIT) begin
            @(posedge sys_clk); #2; n++;
            done = (expq.size() == 0) && !sched_busy && !bus.uart_tx_busy && !pend_to;
            for (int s = 0; s < NREQ; s++) if (srcq[s].size() > 0) done = 1'b0;
        end
        chk({name, "_completes"}, int'(done), 1);
        chk({name, "_bytes_sent"}, int'(bytes_sent), exp_bytes & 16'hFFFF);
        chk({name, "_grant_released"}, int'(bus.grant), 0);
    endtask

    task automatic wait_strobe(input int n0, input string name);
        int n = 0;
        while (n_strobe <= n0 && n < MAX_WAIT) begin @(posedge sys_clk); #2; n++; end
        chk({name, "_strobe_seen"}, int'(n_strobe > n0), 1);
    endtask

    // Source drivers: present bytes in order, honour per-byte pre-delays, pop on transfer.
    initial begin : drv
        item_t it;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        for (int s = 0; s < NREQ; s++) begin
            presenting[s] = 1'b0; took[s] = 1'b0; at_start[s] = 1'b1; wait_cnt[s] = 0; start_cyc[s] = 0;
        end
        forever begin
            @(negedge sys_clk);
            for (int s = 0; s < NREQ; s++) begin
                if (took[s] && srcq[s].size() > 0) begin
                    it = srcq[s].pop_front();
                    at_start[s] = it.last;
                    presenting[s] = 1'b0;
                    wait_cnt[s] = (srcq[s].size() > 0) ? srcq[s][0].dly : 0;
                end
                took[s] = 1'b0;
                if (!presenting[s] && srcq[s].size() > 0) begin
                    if (wait_cnt[s] > 0) begin
                        wait_cnt[s]--;
                    end else begin
                        presenting[s] = 1'b1;
                        if (at_start[s]) start_cyc[s] = cyc;
                    end
                end
                bus.req_valid[s]      = presenting[s];
                bus.req_data[8*s +: 8] = presenting[s] ? srcq[s][0].d : 8'h00;
                bus.req_last[s]       = presenting[s] ? srcq[s][0].last : 1'b0;
            end
            #1;
            for (int s = 0; s < NREQ; s++) took[s] = presenting[s] && bus.req_ready[s];
        end
    end

    // uart_send stand-in: busy rises two cycles after the strobe, lasts a random span.
    initial begin : uart_model
        int rise_cd = 0, fall_cd = 0;
        bus.uart_tx_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                bus.uart_tx_busy = 1'b0; rise_cd = 0; fall_cd = 0;
            end else if (bus.uart_en && busy_en) begin
                rise_cd = 2;
            end else if (rise_cd > 0) begin
                rise_cd--;
                if (rise_cd == 0) begin
                    bus.uart_tx_busy = 1'b1;
                    fall_cd = $urandom_range(3, 12);
                end
            end else if (bus.uart_tx_busy) begin
                fall_cd--;
                if (fall_cd == 0) bus.uart_tx_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk); #1;
            cyc++;
            if (sys_rst_n) begin
                chk("ready_onehot0", int'($countones(bus.req_ready) <= 1), 1);
                chk("ready_within_grant", int'(bus.req_ready & ~bus.grant), 0);
                chk("grant_onehot0", int'($onehot0(bus.grant)), 1);
                if (bus.uart_tx_busy) chk("din_stable_busy", int'(bus.uart_din), int'(held_din));
                if (bus.uart_en) begin
                    chk("en_back_to_back", int'(prev_en), 0);
                    chk("en_while_busy", int'(bus.uart_tx_busy), 0);
                    n_strobe++;
                    if (first_strobe < 0) begin first_strobe = cyc; first_grant = int'(bus.grant); end
                    last_strobe = cyc;
                    held_din = bus.uart_din;
                    if (expq.size() == 0) begin
                        chk("unexpected_strobe_din", int'(bus.uart_din), -1);
                    end else begin
                        e = expq.pop_front();
                        chk("strobe_grant", int'(bus.grant), 1 << e.src);
                        chk("strobe_din", int'(bus.uart_din), int'(e.d));
                        if (e.to) pend_to = 1'b1;
                    end
                end
                if (timeout_err) begin
                    n_timeout++;
                    chk("timeout_expected", int'(pend_to), 1);
                    chk("timeout_latency", cyc - last_strobe, 10);
                    pend_to = 1'b0;
                end else if (pend_to && (cyc - last_strobe) > 10) begin
                    chk("timeout_missing", 0, 1);
                    pend_to = 1'b0;
                end
                prev_en = bus.uart_en;
            end else begin
                prev_en = 1'b0;
                pend_to = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ns, nt, nm, len;
        clear_all();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_uart_en", int'(bus.uart_en), 0);
        chk("rst_uart_din", int'(bus.uart_din), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_sched_busy", int'(sched_busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_bytes_sent", int'(bytes_sent), 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;

        // Two-byte message from source 0.
        @(posedge sys_clk); #2;
        first_strobe = -1; ns = n_strobe;
        mb[0] = 8'h55; mb[1] = 8'hAA; add_msg(0, 2, 0); plan(1'b0);
        wait_done("t1");
        chk("t1_valid_to_strobe", first_strobe - start_cyc[0], 2);
        chk("t1_strobe_count", n_strobe - ns, 2);

        // Simultaneous requests after reset, then rotation.
        do_reset();
        mb[0] = 8'h10; mb[1] = 8'h11; add_msg(0, 2, 0);
        mb[0] = 8'h12; add_msg(0, 1, 0);
        mb[0] = 8'h20; mb[1] = 8'h21; add_msg(1, 2, 0);
        plan(1'b0);
        wait_done("t2");
        first_strobe = -1;
        mb[0] = 8'h30; add_msg(0, 1, 0);
        mb[0] = 8'h40; add_msg(1, 1, 0);
        plan(1'b0);
        wait_done("t2b");
        chk("t2b_first_grant", first_grant, 2);

        // Source 1 arrives while source 0 is mid-message.
        ns = n_strobe;
        mb[0] = 8'hA1; mb[1] = 8'hA2; mb[2] = 8'hA3; add_msg(0, 3, 2); plan(1'b0);
        wait_strobe(ns, "t3");
        mb[0] = 8'hB1; add_msg(1, 1, 0); plan(1'b0);
        wait_done("t3");

        // Busy never rises: each single-byte message aborts.
        busy_en = 1'b0; nt = n_timeout;
        mb[0] = 8'hC3; add_msg(0, 1, 0);
        mb[0] = 8'h3C; add_msg(1, 1, 0);
        plan(1'b1);
        wait_done("t4");
        chk("t4_timeout_count", n_timeout - nt, 2);
        busy_en = 1'b1;

        // Owner stalls 100 cycles between bytes while another source waits.
        ns = n_strobe;
        mb[0] = 8'h50; mb[1] = 8'h51; add_msg(0, 2, 100);
        mb[0] = 8'h60; add_msg(1, 1, 0);
        plan(1'b0);
        wait_strobe(ns, "t5");
        repeat (60) @(posedge sys_clk);
        #2;
        chk("t5_grant_held", int'(bus.grant), 1);
        chk("t5_no_extra_strobe", n_strobe - ns, 1);
        chk("t5_no_ready", int'(bus.req_ready), 0);
        chk("t5_sched_busy", int'(sched_busy), 1);
        wait_done("t5");

        // Reset while waiting for busy to fall.
        ns = n_strobe;
        mb[0] = 8'h70; mb[1] = 8'h71; mb[2] = 8'h72; add_msg(0, 3, 0); plan(1'b0);
        wait_strobe(ns, "t6");
        nm = 0;
        while (!bus.uart_tx_busy && nm < 50) begin @(posedge sys_clk); #2; nm++; end
        chk("t6_busy_seen", int'(bus.uart_tx_busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", int'(bus.grant), 0);
        chk("t6_rst_uart_en", int'(bus.uart_en), 0);
        chk("t6_rst_uart_din", int'(bus.uart_din), 0);
        chk("t6_rst_sched_busy", int'(sched_busy), 0);
        chk("t6_rst_bytes_sent", int'(bytes_sent), 0);
        clear_all();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        @(posedge sys_clk); #2;
        mb[0] = 8'h31; add_msg(0, 1, 0); plan(1'b0);
        wait_done("t6");

        // Randomized traffic.
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < NREQ; s++) begin
                nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) mb[i] = 8'($urandom);
                    add_msg(s, len, $urandom_range(0, 4));
                end
            end
            plan(1'b0);
            wait_done("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
